// File: rtl/vend_payment.sv
// Payment collector for the vending machine: latches an item price on select,
// accumulates coin pulses until the price is covered, then issues a one-cycle
// vend (with change) or a one-cycle refund on cancel. All outputs are registered.
module vend_payment #(
  parameter int unsigned PRICE_HI  = 100,  // code 11
  parameter int unsigned PRICE_MID = 75,   // codes 01 and 10
  parameter int unsigned PRICE_LO  = 50    // code 00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       w0,
  input  logic       w1,
  input  logic       sel,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       cancel,
  output logic       busy,
  output logic [7:0] credit,
  output logic [7:0] price_out,
  output logic       vend,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StVend    = 2'd2;
  localparam logic [1:0] StRefund  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] price_q, price_d;
  logic [7:0] change_q, change_d;
  logic       vend_q, vend_d;
  logic       change_valid_q, change_valid_d;
  logic       coin_reject_q, coin_reject_d;
  logic       busy_q, busy_d;

  logic [1:0] coin_cnt;
  logic       any_coin;
  logic       multi_coin;
  logic [7:0] coin_val;
  logic [7:0] credit_sum;
  logic [7:0] price_sel;

  // Coin decode: quarter beats dime beats nickel; extra coins count as rejects.
  always_comb begin
    coin_cnt   = 2'(nickel) + 2'(dime) + 2'(quarter);
    any_coin   = nickel | dime | quarter;
    multi_coin = (coin_cnt > 2'd1);
    if (quarter)     coin_val = 8'd25;
    else if (dime)   coin_val = 8'd10;
    else if (nickel) coin_val = 8'd5;
    else             coin_val = 8'd0;
    // Prices are limited to 230 so the final overshoot still fits in 8 bits.
    credit_sum = credit_q + coin_val;
  end

  // Item code to price lookup.
  always_comb begin
    unique case ({w1, w0})
      2'b11:   price_sel = 8'(PRICE_HI);
      2'b00:   price_sel = 8'(PRICE_LO);
      default: price_sel = 8'(PRICE_MID);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    change_d       = change_q;
    vend_d         = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        coin_reject_d = any_coin;
        if (sel) begin
          price_d  = price_sel;
          credit_d = 8'd0;
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (cancel) begin
          // Cancel wins over any coin in the same cycle; credit is returned as-is.
          coin_reject_d  = any_coin;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          state_d        = StRefund;
        end else if (any_coin) begin
          coin_reject_d = multi_coin;
          credit_d      = credit_sum;
          if (credit_sum >= price_q) begin
            vend_d         = 1'b1;
            change_valid_d = 1'b1;
            change_d       = credit_sum - price_q;
            state_d        = StVend;
          end
        end
      end
      StVend, StRefund: begin
        // One-cycle strobe states; late coins are handed back.
        coin_reject_d = any_coin;
        credit_d      = 8'd0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      credit_q       <= 8'd0;
      price_q        <= 8'd0;
      change_q       <= 8'd0;
      vend_q         <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      change_q       <= change_d;
      vend_q         <= vend_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign credit       = credit_q;
  assign price_out    = price_q;
  assign vend         = vend_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_payment.sv
// Self-checking bench for vend_payment: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a
// transaction-level model of the payment rules.
module tb_vend_payment;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       w0 = 1'b0, w1 = 1'b0, sel = 1'b0;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
  logic       busy, vend, change_valid, coin_reject;
  logic [7:0] credit, price_out, change;

  int passes = 0;
  int total  = 0;
  bit started = 1'b0;

  vend_payment dut (
    .clk          (clk),
    .resetn       (resetn),
    .w0           (w0),
    .w1           (w1),
    .sel          (sel),
    .nickel       (nickel),
    .dime         (dime),
    .quarter      (quarter),
    .cancel       (cancel),
    .busy         (busy),
    .credit       (credit),
    .price_out    (price_out),
    .vend         (vend),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // in_txn: a purchase is open and coins are being taken.
  // strobe_pending: the single vend/refund cycle is showing.
  bit m_in_txn = 0, m_strobe = 0;
  int m_credit = 0, m_price = 0, m_change = 0;
  bit m_vend = 0, m_cv = 0, m_rej = 0;

  function automatic int price_of(input logic a, input logic b);
    if (a && b) return 100;
    if (!a && !b) return 50;
    return 75;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_in_txn = 0; m_strobe = 0;
      m_credit = 0; m_price = 0; m_change = 0;
      m_vend = 0; m_cv = 0; m_rej = 0;
    end else begin
      int ncoins;
      ncoins = int'(nickel) + int'(dime) + int'(quarter);
      m_vend = 0; m_cv = 0; m_rej = 0;
      if (m_strobe) begin
        m_strobe = 0; m_in_txn = 0; m_credit = 0;
        m_rej = (ncoins > 0);
      end else if (!m_in_txn) begin
        m_rej = (ncoins > 0);
        if (sel) begin
          m_price = price_of(w1, w0);
          m_credit = 0;
          m_in_txn = 1;
        end
      end else if (cancel) begin
        m_rej = (ncoins > 0);
        m_change = m_credit;
        m_cv = 1; m_strobe = 1;
      end else if (ncoins > 0) begin
        m_rej = (ncoins > 1);
        m_credit += quarter ? 25 : (dime ? 10 : 5);
        if (m_credit >= m_price) begin
          m_vend = 1; m_cv = 1; m_strobe = 1;
          m_change = m_credit - m_price;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("credit", int'(credit), m_credit);
      chk("price_out", int'(price_out), m_price);
      chk("busy", int'(busy), int'(m_in_txn));
      chk("vend", int'(vend), int'(m_vend));
      chk("change_valid", int'(change_valid), int'(m_cv));
      chk("coin_reject", int'(coin_reject), int'(m_rej));
      chk("change", int'(change), m_change);
      if (vend) chk("change_range", int'(change <= 8'd20), 1);
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs, let the edge pass, sample 2 ns later.
  task automatic drive(input logic s, input logic a, input logic b, input logic n,
                       input logic d, input logic q, input logic c);
    @(negedge clk);
    sel = s; w1 = a; w0 = b; nickel = n; dime = d; quarter = q; cancel = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    started = 1'b1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_price", int'(price_out), 0);

    // 1: code 11, four quarters -> vend with zero change
    drive(1, 1, 1, 0, 0, 0, 0);
    chk("t1_busy", int'(busy), 1);
    chk("t1_price", int'(price_out), 100);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t1_credit", int'(credit), 25 * i);
    end
    chk("t1_vend", int'(vend), 1);
    chk("t1_change", int'(change), 0);
    idle();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_credit_after", int'(credit), 0);

    // 2: code 01, q q d q -> credit 85, change 10
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("t2_price", int'(price_out), 75);
    drive(0, 0, 0, 0, 0, 1, 0); chk("t2_c1", int'(credit), 25);
    drive(0, 0, 0, 0, 0, 1, 0); chk("t2_c2", int'(credit), 50);
    drive(0, 0, 0, 0, 1, 0, 0); chk("t2_c3", int'(credit), 60);
    drive(0, 0, 0, 0, 0, 1, 0); chk("t2_c4", int'(credit), 85);
    chk("t2_vend", int'(vend), 1);
    chk("t2_change", int'(change), 10);
    idle();
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("t2_price10", int'(price_out), 75);
    drive(0, 0, 0, 0, 0, 0, 1);   // zero-credit refund
    chk("t2_refund_cv", int'(change_valid), 1);
    chk("t2_refund_change", int'(change), 0);
    idle();

    // 3: code 00, dime, nickel, cancel -> refund 15
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t3_price", int'(price_out), 50);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t3_credit", int'(credit), 15);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_cv", int'(change_valid), 1);
    chk("t3_change", int'(change), 15);
    chk("t3_vend", int'(vend), 0);
    idle();
    chk("t3_busy", int'(busy), 0);

    // 4: simultaneous coins, then cancel with a coin
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("t4_credit", int'(credit), 25);
    chk("t4_reject", int'(coin_reject), 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("t4_refund", int'(change), 25);
    chk("t4_reject2", int'(coin_reject), 1);
    idle();

    // 5: coin in IDLE, coin during VEND
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t5_idle_reject", int'(coin_reject), 1);
    chk("t5_idle_credit", int'(credit), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("t5_vend", int'(vend), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t5_vend_reject", int'(coin_reject), 1);
    chk("t5_vend_credit", int'(credit), 0);
    idle();

    // 6: async reset mid-transaction
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("t6_credit", int'(credit), 50);
    sel = 0; quarter = 0;
    resetn = 1'b0;
    #1;
    chk("t6_rst_credit", int'(credit), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_price", int'(price_out), 0);
    chk("t6_rst_cv", int'(change_valid), 0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    chk("t6_no_cv", int'(change_valid), 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("t6_price", int'(price_out), 75);
    chk("t6_new_credit", int'(credit), 0);
    chk("t6_new_busy", int'(busy), 1);
    idle();

    // Randomized traffic, checked each cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 24) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/vend_payment.md
# vend_payment

Sequential payment collector for the vending-machine final project. It latches a 2-bit item code (`w1`,`w0`), where 11 selects the high price, 01 or 10 the middle price, and 00 the low price. It then accumulates coin pulses until the credit covers the price. When it does, it issues a one-cycle vend with the change owed. It sits upstream of the price display decoder and consumes the same item code the decoder displays. Its vend and change outputs drive the dispenser and change logic.

## Interface
Parameters:
- `PRICE_HI`, 100: price in cents for code 11.
- `PRICE_MID`, 75: price in cents for codes 01 and 10.
- `PRICE_LO`, 50: price in cents for code 00.

All three prices must be at most 230, because credit is 8-bit and can overshoot by up to 25.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `w0`, `w1`  in  1 each  item code, sampled only when `sel` is high in IDLE.
- `sel`  in  1  one-cycle select strobe.
- `nickel`, `dime`, `quarter`  in  1 each  one-cycle coin pulses (5/10/25 cents), already synchronized and debounced.
- `cancel`  in  1  one-cycle refund request.
- `busy`  out  1  high in COLLECT, VEND and REFUND.
- `credit`  out  8  current accumulated credit in cents.
- `price_out`  out  8  latched price of the current transaction.
- `vend`  out  1  one-cycle dispense pulse.
- `change`  out  8  cents returned; valid only while `change_valid` is high.
- `change_valid`  out  1  one-cycle strobe, asserted with `vend` or on refund.
- `coin_reject`  out  1  one-cycle pulse for every rejected coin event.

## Operation
- **States:** IDLE, COLLECT, VEND, REFUND. All outputs are registered.
- **Reset (async, `resetn`=0):** state=IDLE, `credit`=0, `price_out`=0, `change`=0. `vend`, `change_valid`, `coin_reject` and `busy` all 0.
- **IDLE:**
  - `sel`=1 latches `price_out` from {`w1`,`w0`}, clears `credit` to 0, and moves to COLLECT.
  - Any coin pulse in IDLE is rejected (`coin_reject` pulses). `cancel` is ignored.
- **COLLECT:**
  - `sel` is ignored.
  - At most one coin is accepted per cycle, with priority quarter > dime > nickel. If two or more coin inputs are high in the same cycle, the lower-priority coins are dropped and `coin_reject` pulses once.
  - The accepted coin is added to `credit` (new_credit = credit + coin value).
  - If new_credit >= `price_out`, go to VEND.
  - `cancel`=1 takes precedence over any coin in the same cycle. All coins that cycle are rejected (`coin_reject`=1 if any were present) and the block goes to REFUND with `credit` unchanged.
- **VEND** (one cycle):
  - `vend`=1, `change_valid`=1, `change`=`credit`-`price_out`.
  - Next state is IDLE, and `credit` clears to 0 on exit.
  - Coins arriving in VEND are rejected.
- **REFUND** (one cycle):
  - `change_valid`=1, `change`=`credit`, `vend`=0.
  - Next state is IDLE, and `credit` clears to 0.
  - A refund with `credit`=0 is legal and gives `change`=0.
- **Width rules:**
  - Credit never exceeds price+20, since the final coin is at most 25 and credit before it is at most price-5.
  - 8 bits is sufficient under the price limit above; no saturation logic is needed.
  - `change` = credit-price is always in 0..20 on vend.
- `change` holds its last value after `change_valid` drops. Consumers use it only under the strobe.

## Timing
- Selection: `sel` is sampled at edge N. COLLECT, `busy`=1 and the latched `price_out` are all visible after edge N.
- Coin: sampled at edge N, and `credit` is updated after edge N.
- If the price is met at edge N, `vend`, `change_valid` and `change` are high for the single cycle between edges N and N+1. `busy` drops and `credit`=0 after edge N+1.
- Cancel: sampled at edge N, and the refund strobe is high between edges N and N+1.
- `coin_reject` is high in the cycle following the offending sample edge, for exactly one cycle.
- Reset asserted mid-transaction discards credit with no refund strobe. After release, the block waits in IDLE for `sel`.

## Test plan
1. Reset, then `sel` with code 11 followed by four `quarter` pulses. Required: `credit` steps 25/50/75/100, one `vend` pulse with `change`=0, then `busy`=0 and `credit`=0.
2. Code 01, then coins quarter, quarter, dime, quarter. Required: `credit` 25/50/60/85, then `vend`=1 with `change`=10. Also check that code 10 latches `price_out`=75.
3. Code 00, then `dime` followed by `nickel`, then `cancel`. Required: `credit`=15, one `change_valid` pulse with `change`=15, `vend`=0, then return to IDLE.
4. In COLLECT, drive `quarter` and `dime` high in the same cycle. Required: credit rises by 25 and `coin_reject` pulses once. Then drive `cancel` and `nickel` high in the same cycle. Required: refund equals the prior credit and `coin_reject`=1.
5. Pulse a coin in IDLE and a coin during the VEND cycle. Required: `coin_reject` each time, and `credit` unchanged/0.
6. Code 11, two quarters (`credit`=50), then assert `resetn`=0 asynchronously between edges. Required: all outputs drop to reset values immediately, no `change_valid` pulse, and after release `sel` starts a clean transaction.
